// File: rtl/word_port_responder_if.sv
// word_port_responder_if: control and strobe signals of one 16-bit word port.
// The responder uses the slave modport. The master modport is the environment
// around it: the 68040 initiator, which drives TSn/SELn/RnW/SIZ/A_AMIGA, and the
// slow peripheral, which drives DTACKn.
// The data lanes and DEV_D are bidirectional. They stay as plain inout ports on
// the responder, so tri-state resolution happens on ordinary nets.
interface word_port_responder_if;
  logic       TSn;
  logic       SELn;
  logic       RnW;
  logic [1:0] SIZ;
  logic [1:0] A_AMIGA;
  logic       PORTSIZE;
  logic       TACKn;
  logic       TEAn;
  logic       ASn;
  logic       UDSn;
  logic       LDSn;
  logic       DEV_RnW;
  logic       DTACKn;

  modport master (
    output TSn, SELn, RnW, SIZ, A_AMIGA, DTACKn,
    input  PORTSIZE, TACKn, TEAn, ASn, UDSn, LDSn, DEV_RnW
  );

  modport slave (
    input  TSn, SELn, RnW, SIZ, A_AMIGA, DTACKn,
    output PORTSIZE, TACKn, TEAn, ASn, UDSn, LDSn, DEV_RnW
  );
endinterface

// File: rtl/word_port_responder.sv
// word_port_responder: runs one AS/UDS/LDS strobe cycle on a 16-bit peripheral
// for each transfer start from the 68040 initiator, then answers with TACKn.
// Data always moves on the UU/UM lanes at offset $0.
// Optional build macro WAIT_TIMEOUT_EN adds a device-acknowledge timeout that
// ends the cycle with TEAn. Without it, STROBE waits for DTACKn indefinitely.
module word_port_responder #(
  parameter logic [7:0] TIMEOUT = 8'd255
) (
  input  logic                  CLK80,
  input  logic                  RESETn,
  word_port_responder_if.slave  bus,
  inout  wire  [7:0]            D_UU_AMIGA,
  inout  wire  [7:0]            D_UM_AMIGA,
  inout  wire  [15:0]           DEV_D
);

  typedef enum logic [2:0] {
    IDLE, SETUP, STROBE, LATCH, ACK0, ACK1, RECOVER
  } state_t;

  state_t      state, state_nx;
  logic        ts_q;
  logic        dtack_s1, dtack_s2;
  logic        pending;
  logic        rnw_q;
  logic [1:0]  siz_q;
  logic        a0_q;
  logic [15:0] wr_data;
  logic [15:0] rd_data;
  logic        ts_start;
  logic        start;
  logic        strobe_on;
  logic        byte_xfer;
  logic        rd_drive, wr_drive;
  logic        unused_bits;

`ifdef WAIT_TIMEOUT_EN
  logic [7:0]  cnt;
  logic        to_q;
  logic        timeout_hit;
`endif

  // TSn is held low for a whole CLK40 period, which is two CLK80 samples.
  // Only the first low sample counts as a start; otherwise every transfer
  // would also set the pending flag.
  assign ts_start = ~bus.TSn & ts_q & ~bus.SELn;

  // A_AMIGA[1] is not needed for a word port, and TIMEOUT is unused when the
  // timeout logic is left out.
  assign unused_bits = ^{bus.A_AMIGA[1], TIMEOUT};

  // Next-state logic for the strobe cycle sequencer.
  always_comb begin
    state_nx = state;
    start    = 1'b0;
`ifdef WAIT_TIMEOUT_EN
    timeout_hit = 1'b0;
`endif
    case (state)
      IDLE: begin
        if (ts_start || pending) begin
          start    = 1'b1;
          state_nx = SETUP;
        end
      end
      SETUP:  state_nx = STROBE;
      STROBE: begin
        if (!dtack_s2) begin
          state_nx = LATCH;
        end
`ifdef WAIT_TIMEOUT_EN
        else if (cnt == TIMEOUT - 8'd1) begin
          timeout_hit = 1'b1;
          state_nx    = ACK0;
        end
`endif
      end
      LATCH:  state_nx = ACK0;
      ACK0:   state_nx = ACK1;
      ACK1:   state_nx = RECOVER;
      RECOVER: begin
`ifdef WAIT_TIMEOUT_EN
        if (dtack_s2 || to_q) state_nx = IDLE;
`else
        if (dtack_s2) state_nx = IDLE;
`endif
      end
      default: state_nx = IDLE;
    endcase
  end

  // State register, DTACKn synchroniser, pending start and the cycle's latched
  // attributes and data.
  always_ff @(posedge CLK80) begin
    if (!RESETn) begin
      state    <= IDLE;
      ts_q     <= 1'b1;
      dtack_s1 <= 1'b1;
      dtack_s2 <= 1'b1;
      pending  <= 1'b0;
      rnw_q    <= 1'b1;
      siz_q    <= 2'b00;
      a0_q     <= 1'b0;
      wr_data  <= 16'h0000;
      rd_data  <= 16'h0000;
    end else begin
      state    <= state_nx;
      ts_q     <= bus.TSn;
      dtack_s1 <= bus.DTACKn;
      dtack_s2 <= dtack_s1;
      if (state == IDLE) begin
        pending <= 1'b0;
      end else if (ts_start) begin
        pending <= 1'b1;
      end
      if (start) begin
        rnw_q   <= bus.RnW;
        siz_q   <= bus.SIZ;
        a0_q    <= bus.A_AMIGA[0];
        wr_data <= {D_UU_AMIGA, D_UM_AMIGA};
      end
      if (state == LATCH && rnw_q) begin
        rd_data <= DEV_D;
      end
`ifdef WAIT_TIMEOUT_EN
      if (timeout_hit) begin
        rd_data <= 16'hFFFF;
      end
`endif
    end
  end

`ifdef WAIT_TIMEOUT_EN
  // Counts STROBE cycles. It clears at each new start, and to_q remembers
  // that the cycle ended by timeout.
  always_ff @(posedge CLK80) begin
    if (!RESETn) begin
      cnt  <= 8'd0;
      to_q <= 1'b0;
    end else begin
      if (start) begin
        cnt  <= 8'd0;
        to_q <= 1'b0;
      end else begin
        if (state == STROBE) cnt <= cnt + 8'd1;
        if (timeout_hit) to_q <= 1'b1;
      end
    end
  end
`endif

  // Strobes and acknowledges are decoded from the registered state.
  // They change only at clock edges and go inactive on the first reset edge.
  assign byte_xfer = (siz_q == 2'b01);
  assign strobe_on = (state == STROBE) || (state == LATCH) || (state == ACK0);

  assign bus.PORTSIZE = ~bus.SELn;
  assign bus.ASn      = ~((state == SETUP) || strobe_on);
  assign bus.UDSn     = ~(strobe_on && !(byte_xfer && a0_q));
  assign bus.LDSn     = ~(strobe_on && !(byte_xfer && !a0_q));
  assign bus.TACKn    = ~((state == ACK0) || (state == ACK1));
  assign bus.DEV_RnW  = rnw_q;
`ifdef WAIT_TIMEOUT_EN
  assign bus.TEAn     = ~(to_q && ((state == ACK0) || (state == ACK1)));
`else
  assign bus.TEAn     = 1'b1;
`endif

  // Read data goes back to the initiator only while TACKn is low. Write data
  // drives the device bus from SETUP until the acknowledge finishes.
  assign rd_drive = rnw_q && ((state == ACK0) || (state == ACK1));
  assign wr_drive = !rnw_q && (state inside {SETUP, STROBE, LATCH, ACK0, ACK1});

  assign D_UU_AMIGA = rd_drive ? rd_data[15:8] : 8'hzz;
  assign D_UM_AMIGA = rd_drive ? rd_data[7:0]  : 8'hzz;
  assign DEV_D      = wr_drive ? wr_data       : 16'hzzzz;

endmodule

// File: tb/tb_word_port_responder.sv
// tb_word_port_responder: directed and randomised strobe cycles for
// word_port_responder. Expected strobes, data and latencies come from the
// port's behavioural rules. WAIT_TIMEOUT_EN enables the timeout scenario.
module tb_word_port_responder;

  localparam logic [7:0] TB_TIMEOUT = 8'd8;

  logic        CLK80 = 1'b0;
  logic        RESETn;
  wire  [7:0]  d_uu, d_um;
  wire  [15:0] dev_d;
  logic        tb_d_oe;
  logic [15:0] tb_d_val;
  logic        dev_oe;
  logic [15:0] dev_val;
  int          checks = 0;
  int          failures = 0;

  word_port_responder_if bus_if();

  assign d_uu  = tb_d_oe ? tb_d_val[15:8] : 8'hzz;
  assign d_um  = tb_d_oe ? tb_d_val[7:0]  : 8'hzz;
  assign dev_d = dev_oe  ? dev_val        : 16'hzzzz;

  word_port_responder #(.TIMEOUT(TB_TIMEOUT)) dut (
    .CLK80      (CLK80),
    .RESETn     (RESETn),
    .bus        (bus_if),
    .D_UU_AMIGA (d_uu),
    .D_UM_AMIGA (d_um),
    .DEV_D      (dev_d)
  );

  // 80 MHz-style free-running clock.
  always #5 CLK80 = ~CLK80;

  // Hard stop in case a sequence goes astray.
  initial begin
    #500000;
    $display("[TB] FAIL watchdog expired checks=%0d failures=%0d", checks, failures);
    $fatal(1, "[TB] watchdog");
  end

  task automatic tick();
    @(posedge CLK80);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Active-low {UDSn, LDSn} expected in STROBE. A byte selects one lane by A0;
  // every other size uses the whole word.
  function automatic logic [1:0] expStrobes(input logic [1:0] siz, input logic a0);
    if (siz == 2'b01) return a0 ? 2'b10 : 2'b01;
    return 2'b00;
  endfunction

  // Drives zero onto both buses. A bus that the DUT has released reads back zero.
  task automatic probeReleased();
    tb_d_oe  = 1'b1;
    tb_d_val = 16'h0000;
    dev_oe   = 1'b1;
    dev_val  = 16'h0000;
    #1;
    checkOutput("lanes_released", 16'({d_uu, d_um}), 16'h0000);
    checkOutput("dev_d_released", dev_d, 16'h0000);
    tb_d_oe = 1'b0;
    dev_oe  = 1'b0;
  endtask

  // Presents a transfer start. On return, the start edge has passed.
  task automatic applyStimulus(input logic rnw, input logic [1:0] siz, input logic a0,
                               input logic [15:0] wdata);
    bus_if.RnW     = rnw;
    bus_if.SIZ     = siz;
    bus_if.A_AMIGA = {1'($urandom_range(0, 1)), a0};
    bus_if.SELn    = 1'b0;
    if (!rnw) begin
      tb_d_oe  = 1'b1;
      tb_d_val = wdata;
    end
    bus_if.TSn = 1'b0;
    tick();
  endtask

  // From SETUP through ACK0. The device acknowledges dly cycles after the
  // strobes appear.
  task automatic finishCycle(input logic rnw, input logic [1:0] siz, input logic a0,
                             input logic [15:0] wdata, input logic [15:0] rdata, input int dly);
    int n;
    logic [1:0] es;
    es = expStrobes(siz, a0);
    checkOutput("setup_asn", 16'(bus_if.ASn), 16'h0);
    checkOutput("setup_ds", 16'({bus_if.UDSn, bus_if.LDSn}), 16'h3);
    checkOutput("setup_dev_rnw", 16'(bus_if.DEV_RnW), 16'(rnw));
    if (!rnw) checkOutput("setup_dev_d", dev_d, wdata);
    tick();
    bus_if.TSn = 1'b1;
    checkOutput("strobe_ds", 16'({bus_if.UDSn, bus_if.LDSn}), 16'(es));
    repeat (dly) begin
      tick();
      checkOutput("tack_early", 16'(bus_if.TACKn), 16'h1);
    end
    bus_if.DTACKn = 1'b0;
    if (rnw) begin
      dev_oe  = 1'b1;
      dev_val = rdata;
    end
    n = 0;
    while (bus_if.TACKn !== 1'b0 && n < 20) begin
      tick();
      n++;
    end
    checkOutput("tack_latency", 16'(n), 16'd4);
    checkOutput("ack0_tean", 16'(bus_if.TEAn), 16'h1);
    checkOutput("ack0_ds", 16'({bus_if.UDSn, bus_if.LDSn}), 16'(es));
    if (rnw) checkOutput("ack0_rd_data", 16'({d_uu, d_um}), rdata);
    else     checkOutput("ack0_dev_d", dev_d, wdata);
  endtask

  // From ACK0 into RECOVER. Optionally issues the next TSn during ACK1 and
  // releases the device acknowledge.
  task automatic ackTail(input logic rnw, input logic [15:0] rdata, input logic ts_next,
                         input logic release_dtack);
    if (release_dtack) begin
      bus_if.DTACKn = 1'b1;
      dev_oe        = 1'b0;
    end
    tick();
    checkOutput("ack1_tackn", 16'(bus_if.TACKn), 16'h0);
    checkOutput("ack1_strobes", 16'({bus_if.ASn, bus_if.UDSn, bus_if.LDSn}), 16'h7);
    if (rnw) checkOutput("ack1_rd_data", 16'({d_uu, d_um}), rdata);
    if (ts_next) begin
      bus_if.TSn  = 1'b0;
      bus_if.SELn = 1'b0;
    end
    tick();
    checkOutput("recover_tackn", 16'(bus_if.TACKn), 16'h1);
    tb_d_oe = 1'b0;
    if (release_dtack) probeReleased();
  endtask

  task automatic runCycle(input logic rnw, input logic [1:0] siz, input logic a0,
                          input logic [15:0] wdata, input logic [15:0] rdata, input int dly);
    applyStimulus(rnw, siz, a0, wdata);
    finishCycle(rnw, siz, a0, wdata, rdata, dly);
    ackTail(rnw, rdata, 1'b0, 1'b1);
    tick();
    tick();
  endtask

  initial begin
    int n;
    logic r_rnw;
    logic [1:0] r_siz;
    logic r_a0;
    logic [15:0] r_wd, r_rd;
    int r_dly;

    RESETn         = 1'b0;
    bus_if.TSn     = 1'b1;
    bus_if.SELn    = 1'b1;
    bus_if.RnW     = 1'b1;
    bus_if.SIZ     = 2'b10;
    bus_if.A_AMIGA = 2'b00;
    bus_if.DTACKn  = 1'b1;
    tb_d_oe  = 1'b0;
    tb_d_val = 16'h0000;
    dev_oe   = 1'b0;
    dev_val  = 16'h0000;
    $display("[TB] start");

    // Reset state.
    tick();
    tick();
    checkOutput("reset_outputs",
                16'({bus_if.ASn, bus_if.UDSn, bus_if.LDSn, bus_if.TACKn, bus_if.TEAn, bus_if.DEV_RnW}),
                16'h3F);
    probeReleased();
    checkOutput("portsize_unselected", 16'(bus_if.PORTSIZE), 16'h0);
    bus_if.SELn = 1'b0;
    #1;
    checkOutput("portsize_selected", 16'(bus_if.PORTSIZE), 16'h1);
    bus_if.SELn = 1'b1;
    RESETn = 1'b1;
    tick();

    // A TSn without SELn starts nothing.
    bus_if.TSn = 1'b0;
    n = 0;
    repeat (6) begin
      tick();
      bus_if.TSn = 1'b1;
      if (bus_if.ASn === 1'b0 || bus_if.TACKn === 1'b0) n++;
    end
    checkOutput("unselected_no_cycle", 16'(n), 16'd0);

    // Word read of A55A with the device acknowledging 3 cycles after the strobes.
    runCycle(1'b1, 2'b10, 1'b0, 16'h0000, 16'hA55A, 3);

    // Byte write to the odd address puts 3C on the low byte, LDSn only.
    runCycle(1'b0, 2'b01, 1'b1, 16'h003C, 16'h0000, 1);

    // Byte read from the even address, UDSn only.
    runCycle(1'b1, 2'b01, 1'b0, 16'h0000, 16'h7E81, 0);

    // Back-to-back: the second start arrives during ACK1 and is held pending.
    applyStimulus(1'b1, 2'b10, 1'b0, 16'h0000);
    finishCycle(1'b1, 2'b10, 1'b0, 16'h0000, 16'h1234, 2);
    bus_if.SIZ     = 2'b00;
    bus_if.A_AMIGA = 2'b00;
    ackTail(1'b1, 16'h1234, 1'b1, 1'b1);
    tick();
    bus_if.TSn = 1'b1;
    checkOutput("pending_idle_asn", 16'(bus_if.ASn), 16'h1);
    tick();
    finishCycle(1'b1, 2'b00, 1'b0, 16'h0000, 16'hC3D2, 1);
    ackTail(1'b1, 16'hC3D2, 1'b0, 1'b1);
    n = 0;
    repeat (6) begin
      tick();
      if (bus_if.ASn === 1'b0) n++;
    end
    checkOutput("no_third_cycle", 16'(n), 16'd0);

    // DTACKn held low past ACK1 keeps the port in RECOVER, even with a start pending.
    applyStimulus(1'b1, 2'b10, 1'b0, 16'h0000);
    finishCycle(1'b1, 2'b10, 1'b0, 16'h0000, 16'h5AA5, 0);
    ackTail(1'b1, 16'h5AA5, 1'b1, 1'b0);
    n = 0;
    repeat (10) begin
      tick();
      bus_if.TSn = 1'b1;
      if (bus_if.ASn === 1'b0) n++;
    end
    checkOutput("recover_hold_asn", 16'(n), 16'd0);
    bus_if.DTACKn = 1'b1;
    dev_oe = 1'b0;
    n = 0;
    while (bus_if.ASn !== 1'b0 && n < 20) begin
      tick();
      n++;
    end
    checkOutput("recover_exit_latency", 16'(n), 16'd4);
    finishCycle(1'b1, 2'b10, 1'b0, 16'h0000, 16'h0F0F, 1);
    ackTail(1'b1, 16'h0F0F, 1'b0, 1'b1);
    tick();
    tick();

    // Reset during STROBE of a write drops everything on the first reset edge.
    applyStimulus(1'b0, 2'b10, 1'b0, 16'hBEEF);
    tick();
    bus_if.TSn = 1'b1;
    checkOutput("pre_reset_ds", 16'({bus_if.UDSn, bus_if.LDSn}), 16'h0);
    RESETn = 1'b0;
    tick();
    checkOutput("midreset_outputs",
                16'({bus_if.ASn, bus_if.UDSn, bus_if.LDSn, bus_if.TACKn, bus_if.TEAn, bus_if.DEV_RnW}),
                16'h3F);
    tb_d_oe = 1'b0;
    probeReleased();
    RESETn = 1'b1;
    tick();
    runCycle(1'b1, 2'b10, 1'b0, 16'h0000, 16'h6789, 2);

    // Randomised transfers against the port model.
    for (int i = 0; i < 10; i++) begin
      r_rnw = 1'($urandom_range(0, 1));
      r_siz = 2'($urandom_range(0, 3));
      r_a0  = 1'($urandom_range(0, 1));
      r_wd  = 16'($urandom);
      r_rd  = 16'($urandom);
      r_dly = $urandom_range(0, 4);
      runCycle(r_rnw, r_siz, r_a0, r_wd, r_rd, r_dly);
    end

`ifdef WAIT_TIMEOUT_EN
    // With no device acknowledge, TIMEOUT STROBE cycles end in TACKn plus TEAn.
    applyStimulus(1'b1, 2'b10, 1'b0, 16'h0000);
    tick();
    bus_if.TSn = 1'b1;
    n = 0;
    while (bus_if.TACKn !== 1'b0 && n < 300) begin
      tick();
      n++;
    end
    checkOutput("timeout_latency", 16'(n), 16'(TB_TIMEOUT));
    checkOutput("timeout_tean_ack0", 16'(bus_if.TEAn), 16'h0);
    checkOutput("timeout_data_ack0", 16'({d_uu, d_um}), 16'hFFFF);
    tick();
    checkOutput("timeout_ack1", 16'({bus_if.TACKn, bus_if.TEAn}), 16'h0);
    checkOutput("timeout_data_ack1", 16'({d_uu, d_um}), 16'hFFFF);
    tick();
    checkOutput("timeout_end", 16'({bus_if.TACKn, bus_if.TEAn}), 16'h3);
    tick();
    tick();
    runCycle(1'b1, 2'b10, 1'b1, 16'h0000, 16'h2468, 1);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
